// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle arithmetic engine.
// Radix-2 Booth signed multiply, non-restoring unsigned divide and
// non-restoring unsigned square root share one accumulator / Q register
// pair behind an IDLE-LOAD-ITER-FIX-DONE handshake FSM.
module seq_arith_unit #(
   parameter int N  = 8,
   parameter int CW = $clog2(N) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [N-1:0]     data_x,
   input  logic [N-1:0]     data_y,
   output logic [2*N-1:0]   result,
   output logic [N-1:0]     remainder,
   output logic             busy,
   output logic             done,
   output logic             error
);

   typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

   localparam logic [1:0]    OP_MUL  = 2'b00;
   localparam logic [1:0]    OP_DIV  = 2'b01;
   localparam logic [1:0]    OP_SQRT = 2'b10;
   localparam logic [1:0]    OP_RSV  = 2'b11;
   localparam logic [CW-1:0] ITERS_FULL = CW'(N);
   localparam logic [CW-1:0] ITERS_HALF = CW'(N / 2);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   state_t         state, state_nxt;

   // captured transaction
   logic [1:0]     op_r;
   logic [N-1:0]   x_r;     // multiplicand / dividend / radicand (shifted out for sqrt)
   logic [N-1:0]   y_r;     // multiplier / divisor

   // shared working registers
   logic [N+1:0]   acc;     // mul uses [N:0], div uses [N:0], sqrt uses all N+2 bits
   logic [N-1:0]   qreg;    // mul multiplier, div dividend/quotient, sqrt root
   logic           qm1;     // Booth extra LSB
   logic [CW-1:0]  cnt;

   logic           div_zero;
   logic           bad_op;

   // one-step next values
   logic [N+1:0]   acc_step;
   logic [N-1:0]   q_step;
   logic           qm1_step;
   logic [N-1:0]   x_step;

   logic [N:0]     m_ext;
   logic [N:0]     booth_sum;
   logic [N:0]     div_ps;
   logic [N:0]     div_pn;
   logic [N+1:0]   sq_rs;
   logic [N+1:0]   sq_trial;
   logic [N+1:0]   sq_rn;

   // correction-stage values
   logic [N-1:0]   div_rem;
   logic [N+1:0]   sq_fix;
   logic [N+1:0]   sq_back;

   assign div_zero = (op_r == OP_DIV) && (y_r == '0);
   assign bad_op   = div_zero || (op_r == OP_RSV);

   assign busy = (state == LOAD) || (state == ITER) || (state == FIX);
   assign done = (state == DONE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = bad_op ? DONE : ITER;
         ITER:    if (cnt == CNT_ONE) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // single iteration of the selected algorithm
   always_comb begin
      acc_step = acc;
      q_step   = qreg;
      qm1_step = qm1;
      x_step   = x_r;

      // Booth: add/sub on {Q0,Q-1}, then arithmetic shift of {A,Q,Q-1}
      m_ext = {x_r[N-1], x_r};
      case ({qreg[0], qm1})
         2'b01:   booth_sum = acc[N:0] + m_ext;
         2'b10:   booth_sum = acc[N:0] - m_ext;
         default: booth_sum = acc[N:0];
      endcase

      // Non-restoring divide: the (N+1)-bit partial remainder may wrap in the
      // shifted intermediate, but the post-add/sub value always fits.
      div_ps = {acc[N-1:0], qreg[N-1]};
      div_pn = acc[N] ? (div_ps + {1'b0, y_r}) : (div_ps - {1'b0, y_r});

      // Non-restoring sqrt: bring down two radicand bits, trial {root,01|11}
      sq_rs    = {acc[N-1:0], x_r[N-1:N-2]};
      sq_trial = {{(N/2){1'b0}}, qreg[N/2-1:0], acc[N+1], 1'b1};
      sq_rn    = acc[N+1] ? (sq_rs + sq_trial) : (sq_rs - sq_trial);

      case (op_r)
         OP_MUL: begin
            acc_step = {booth_sum[N], booth_sum[N], booth_sum[N:1]};
            q_step   = {booth_sum[0], qreg[N-1:1]};
            qm1_step = qreg[0];
         end
         OP_DIV: begin
            acc_step = {div_pn[N], div_pn};
            q_step   = {qreg[N-2:0], ~div_pn[N]};
         end
         OP_SQRT: begin
            acc_step = sq_rn;
            q_step   = {qreg[N-2:0], ~sq_rn[N+1]};
            x_step   = {x_r[N-3:0], 2'b00};
         end
         default: ;
      endcase
   end

   // final remainder correction (add back divisor / last trial value)
   always_comb begin
      div_rem = acc[N] ? (acc[N-1:0] + y_r) : acc[N-1:0];
      sq_back = {{(N/2+1){1'b0}}, qreg[N/2-1:0], 1'b1};
      sq_fix  = acc[N+1] ? (acc + sq_back) : acc;
   end

   // datapath: capture, load, iterate, commit results
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r      <= '0;
         x_r       <= '0;
         y_r       <= '0;
         acc       <= '0;
         qreg      <= '0;
         qm1       <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         remainder <= '0;
         error     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  x_r  <= data_x;
                  y_r  <= data_y;
               end
            end
            LOAD: begin
               acc <= '0;
               qm1 <= 1'b0;
               cnt <= (op_r == OP_SQRT) ? ITERS_HALF : ITERS_FULL;
               case (op_r)
                  OP_MUL:  qreg <= y_r;
                  OP_DIV:  qreg <= x_r;
                  default: qreg <= '0;
               endcase
               // error completions commit straight from LOAD
               if (bad_op) begin
                  error     <= 1'b1;
                  result    <= div_zero ? '1  : '0;
                  remainder <= div_zero ? x_r : '0;
               end
            end
            ITER: begin
               acc  <= acc_step;
               qreg <= q_step;
               qm1  <= qm1_step;
               x_r  <= x_step;
               cnt  <= cnt - CNT_ONE;
            end
            FIX: begin
               error <= 1'b0;
               case (op_r)
                  OP_MUL: begin
                     result    <= {acc[N-1:0], qreg};
                     remainder <= '0;
                  end
                  OP_DIV: begin
                     result    <= {{N{1'b0}}, qreg};
                     remainder <= div_rem;
                  end
                  default: begin
                     result    <= {{(2*N-N/2){1'b0}}, qreg[N/2-1:0]};
                     remainder <= sq_fix[N-1:0];
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: scoreboard bench for seq_arith_unit (N=8).
// Driver pushes model-derived expectations; an independent monitor pops and
// compares on every done pulse, and checks result hold while busy.
module tb_seq_arith_unit;

   localparam int N = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [1:0]     op;
   logic [N-1:0]   data_x, data_y;
   logic [2*N-1:0] result;
   logic [N-1:0]   remainder;
   logic           busy, done, error;

   seq_arith_unit #(.N(N)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .data_x(data_x), .data_y(data_y),
      .result(result), .remainder(remainder),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*N-1:0] res;
      logic [N-1:0]   rem;
      logic           err;
      int             lat;
      int             acc_cyc;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
   endtask

   // reference model: plain arithmetic
   function automatic exp_t model(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
      exp_t e;
      int p, r;
      e.res = '0; e.rem = '0; e.err = 1'b0; e.lat = 1; e.acc_cyc = 0;
      case (o)
         2'd0: begin
            p = int'($signed(x)) * int'($signed(y));
            e.res = 16'(p);
            e.lat = N + 2;
         end
         2'd1: begin
            if (y == 0) begin
               e.res = '1; e.rem = x; e.err = 1'b1; e.lat = 1;
            end else begin
               e.res = 16'(int'(x) / int'(y));
               e.rem = 8'(int'(x) % int'(y));
               e.lat = N + 2;
            end
         end
         2'd2: begin
            r = 0;
            while ((r + 1) * (r + 1) <= int'(x)) r++;
            e.res = 16'(r);
            e.rem = 8'(int'(x) - r * r);
            e.lat = N / 2 + 2;
         end
         default: begin
            e.err = 1'b1; e.lat = 1;
         end
      endcase
      return e;
   endfunction

   // monitor state
   logic [2*N-1:0] last_res = '0;
   logic [N-1:0]   last_rem = '0;
   logic           last_err = 1'b0;
   int             bsy_cnt  = 0;
   logic           in_reset = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         in_reset = 1'b1;
         last_res = '0; last_rem = '0; last_err = 1'b0;
         bsy_cnt  = 0;
      end else begin
         in_reset = 1'b0;
      end
   end

   // monitor: hold check while busy, scoreboard compare on done
   always @(negedge clk) begin
      if (!rst && !in_reset) begin
         if (busy) begin
            bsy_cnt++;
            chk("hold_result", 32'(result), 32'(last_res));
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(1), 32'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("result",    32'(result),    32'(e.res));
               chk("remainder", 32'(remainder), 32'(e.rem));
               chk("error",     32'(error),     32'(e.err));
               chk("latency",   32'(cyc - e.acc_cyc), 32'(e.lat));
               chk("busy_len",  32'(bsy_cnt),   32'(e.lat));
               chk("busy_in_done", 32'(busy),   32'(0));
               last_res = e.res; last_rem = e.rem; last_err = e.err;
            end
            bsy_cnt = 0;
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while ((busy || done) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("idle_timeout", 32'(1), 32'(0));
   endtask

   // issue one transaction; noise pulses start with junk while not idle
   task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input bit noise);
      exp_t e;
      int t;
      wait_idle();
      op = o; data_x = x; data_y = y; start = 1'b1;
      e = model(o, x, y);
      @(posedge clk);
      #1;
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      start  = 1'b0;
      op     = 2'($urandom);
      data_x = 8'($urandom);
      data_y = 8'($urandom);
      if (noise) begin
         t = 0;
         while ((busy || done) && t < 100) begin
            start  = 1'($urandom_range(0, 1));
            op     = 2'($urandom);
            data_x = 8'($urandom);
            data_y = 8'($urandom);
            @(negedge clk);
            t++;
         end
         start = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = '0; data_x = '0; data_y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   32'(busy),      32'(0));
      chk("rst_done",   32'(done),      32'(0));
      chk("rst_result", 32'(result),    32'(0));
      chk("rst_rem",    32'(remainder), 32'(0));
      chk("rst_error",  32'(error),     32'(0));
      rst = 1'b0;
      @(negedge clk);

      // directed cases
      issue(2'd0, 8'hF9, 8'h05, 1'b0);
      issue(2'd0, 8'h80, 8'h80, 1'b0);
      issue(2'd0, 8'h7F, 8'h80, 1'b0);
      issue(2'd1, 8'd200, 8'd7, 1'b0);
      issue(2'd1, 8'd5, 8'd9, 1'b0);
      issue(2'd1, 8'h2A, 8'h00, 1'b0);
      issue(2'd3, 8'h55, 8'h33, 1'b0);
      issue(2'd2, 8'd200, 8'h00, 1'b0);
      issue(2'd2, 8'd255, 8'hAA, 1'b0);
      issue(2'd2, 8'd0, 8'h00, 1'b0);
      // start pulses during LOAD/ITER/DONE must be ignored
      issue(2'd0, 8'h9C, 8'h3B, 1'b1);
      issue(2'd1, 8'hFF, 8'h01, 1'b1);
      issue(2'd2, 8'hE1, 8'h00, 1'b1);
      drain();

      // reset mid-multiply aborts with no done and cleared outputs
      wait_idle();
      op = 2'd0; data_x = 8'h12; data_y = 8'h34; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy",   32'(busy),      32'(0));
      chk("abort_done",   32'(done),      32'(0));
      chk("abort_result", 32'(result),    32'(0));
      chk("abort_rem",    32'(remainder), 32'(0));
      chk("abort_error",  32'(error),     32'(0));
      repeat (N + 4) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'(0));
      end
      issue(2'd0, 8'h12, 8'h34, 1'b0);
      drain();

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         logic [1:0]   ro;
         logic [N-1:0] rx, ry;
         ro = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
         rx = 8'($urandom);
         ry = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         issue(ro, rx, ry, bit'($urandom_range(0, 3) == 0));
      end
      drain();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
